// File: rtl/digit_scanner_pkg.sv
//==============================================================================
// Module : digit_scanner_pkg
// Brief  : Bank-select codes and active-low 7-segment patterns {g,f,e,d,c,b,a}.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package digit_scanner_pkg;

  typedef logic [6:0] seg_t;

  // State codes shared with the digit-entry logic.
  localparam logic [2:0] SL_A = 3'd0;
  localparam logic [2:0] SL_B = 3'd1;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;

endpackage

`default_nettype wire

// File: rtl/digit_scanner_seg_decoder.sv
//==============================================================================
// Module : seg_decoder
// Brief  : 4-bit hex value to active-low 7-segment pattern (pure case table).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module seg_decoder
  import digit_scanner_pkg::*;
(
  input  logic [3:0] value,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/digit_scanner.sv
//==============================================================================
// Module : digit_scanner
// Brief  : 4-digit multiplexed common-anode display driver with cursor blink.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module digit_scanner
  import digit_scanner_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A1,
  input  logic [3:0] A2,
  input  logic [3:0] A3,
  input  logic [3:0] A4,
  input  logic [3:0] B1,
  input  logic [3:0] B2,
  input  logic [3:0] B3,
  input  logic [3:0] B4,
  input  logic [2:0] ST_L,
  input  logic [1:0] index,
  input  logic       enabled,
  output logic [3:0] an,
  output seg_t       seg,
  output logic       dp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);
  localparam logic [BLK_W-1:0] C_BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [BLK_W-1:0] C_BLK_ONE  = BLK_W'(1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       ptr;
  logic [BLK_W-1:0] blk_cnt;
  logic             blink;

  logic       w_tick;
  logic       w_round;
  logic       w_blink_wrap;
  logic       w_blink_nxt;
  logic [1:0] w_ptr_nxt;
  logic       w_bank_b;
  logic [3:0] w_digit;
  logic       w_cursor;
  seg_t       w_seg;

  assign w_tick       = (div_cnt == C_DIV_LAST);
  assign w_ptr_nxt    = ptr + 2'd1;
  assign w_round      = w_tick && (ptr == 2'd3);
  assign w_blink_wrap = w_round && (blk_cnt == C_BLK_LAST);
  // The digit-1 load on a round edge must already see the toggled phase.
  assign w_blink_nxt  = blink ^ w_blink_wrap;
  assign w_bank_b     = (ST_L == SL_B);
  assign w_cursor     = enabled && (index == w_ptr_nxt);

  always_comb begin
    w_digit = 4'h0;
    case (w_ptr_nxt)
      2'd0: w_digit = w_bank_b ? B1 : A1;
      2'd1: w_digit = w_bank_b ? B2 : A2;
      2'd2: w_digit = w_bank_b ? B3 : A3;
      2'd3: w_digit = w_bank_b ? B4 : A4;
      default: w_digit = 4'h0;
    endcase
  end

  seg_decoder u_seg_decoder (
    .value (w_digit),
    .seg   (w_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      ptr     <= 2'd3;
      blk_cnt <= '0;
      blink   <= 1'b0;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      div_cnt <= w_tick ? '0 : div_cnt + C_DIV_ONE;
      if (w_tick) begin
        ptr <= w_ptr_nxt;
        an  <= ~(4'b0001 << w_ptr_nxt);
        seg <= (w_cursor && w_blink_nxt) ? SEG_BLANK : w_seg;
        dp  <= ~w_cursor;
      end
      if (w_round) begin
        blk_cnt <= w_blink_wrap ? '0 : blk_cnt + C_BLK_ONE;
        blink   <= w_blink_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_digit_scanner.sv
//==============================================================================
// Module : tb_digit_scanner
// Brief  : Scoreboard bench for digit_scanner against an arithmetic scan model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_digit_scanner;
  import digit_scanner_pkg::*;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a_dig [4];
  logic [3:0] b_dig [4];
  logic [2:0] st_l = 3'd0;
  logic [1:0] index = 2'd0;
  logic       enabled = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  // Reference segment table {g,f,e,d,c,b,a}, active-low.
  logic [6:0] ref_seg [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  exp_t sb_q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  digit_scanner #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst),
    .A1(a_dig[0]), .A2(a_dig[1]), .A3(a_dig[2]), .A4(a_dig[3]),
    .B1(b_dig[0]), .B2(b_dig[1]), .B3(b_dig[2]), .B4(b_dig[3]),
    .ST_L(st_l), .index(index), .enabled(enabled),
    .an(an), .seg(seg), .dp(dp)
  );

  // Tick t (1-based) lights digit (t-1)%4; rounds happen on ticks 1,5,9,...
  function automatic exp_t model(input int n);
    exp_t e;
    int t, p, rounds, blk;
    logic cur;
    logic [3:0] v;
    t      = n / SCAN_DIV;
    p      = (t - 1) % 4;
    rounds = (t + 3) / 4;
    blk    = (rounds / BLINK_DIV) % 2;
    v      = (st_l == SL_B) ? b_dig[p] : a_dig[p];
    cur    = enabled && (int'(index) == p);
    e.an   = 4'b1111;
    e.an[p] = 1'b0;
    e.seg  = (cur && blk == 1) ? 7'b1111111 : ref_seg[v];
    e.dp   = !cur;
    return e;
  endfunction

  // Drive inputs for the coming edge, log the expectation, then wait past it.
  task automatic step(input bit rnd);
    cyc++;
    if (rnd) begin
      for (int i = 0; i < 4; i++) begin
        a_dig[i] = 4'($urandom_range(0, 15));
        b_dig[i] = 4'($urandom_range(0, 15));
      end
      st_l    = ($urandom_range(0, 1) == 1) ? SL_B : 3'($urandom_range(0, 7));
      index   = 2'($urandom_range(0, 3));
      enabled = ($urandom_range(0, 3) != 0);
    end
    if (cyc % SCAN_DIV == 0) sb_q.push_back(model(cyc));
    @(negedge clk);
  endtask

  task automatic check_dark(input string name);
    tests++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      fails++;
      $display("FAIL %s: an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
               name, an, seg, dp);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    cyc = 0;
  endtask

  task automatic set_a(input logic [3:0] d1, d2, d3, d4);
    a_dig[0] = d1; a_dig[1] = d2; a_dig[2] = d3; a_dig[3] = d4;
  endtask

  // Monitor: every change of an is one presented output to score.
  logic [3:0] prev_an;
  int         slot;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_an = 4'b1111;
      slot    = 0;
    end else begin
      tests++;
      if (!(an == 4'b1111 || $onehot(~an))) begin
        fails++;
        $display("FAIL an_onehot: an=%b, want 1111 or one low bit", an);
      end
      if (an != prev_an) begin
        tests++;
        if (slot != ((prev_an == 4'b1111) ? SCAN_DIV - 1 : SCAN_DIV)) begin
          fails++;
          $display("FAIL slot_len: an=%b held %0d samples, want %0d", prev_an, slot,
                   (prev_an == 4'b1111) ? SCAN_DIV - 1 : SCAN_DIV);
        end
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: an=%b seg=%b dp=%b, none expected", an, seg, dp);
        end else begin
          e = sb_q.pop_front();
          if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
            fails++;
            $display("FAIL scan_out: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     an, seg, dp, e.an, e.seg, e.dp);
          end
        end
        prev_an = an;
        slot    = 1;
      end else begin
        slot++;
      end
    end
  end

  initial begin
    bit found;
    int t;
    set_a(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 4; i++) b_dig[i] = 4'd0;
    st_l = SL_A;
    repeat (3) @(negedge clk);
    check_dark("reset_dark");
    release_reset();

    // Basic scan from bank A, cursor off.
    repeat (40) step(1'b0);

    // Bank switch to B while a slot is in progress.
    b_dig[0] = 4'd9; b_dig[1] = 4'd8; b_dig[2] = 4'd7; b_dig[3] = 4'd6;
    repeat (2) step(1'b0);
    st_l = SL_B;
    repeat (20) step(1'b0);

    // Cursor blink on digit 3 over several half-periods.
    st_l = SL_A; enabled = 1'b1; index = 2'd2;
    repeat (100) step(1'b0);

    // Every hex code through digit 1 and digit 4.
    enabled = 1'b0;
    for (int v = 0; v < 16; v++) begin
      a_dig[0] = 4'(v);
      a_dig[3] = 4'(15 - v);
      repeat (4 * SCAN_DIV) step(1'b0);
    end

    repeat (10000) step(1'b1);

    // Reset in the middle of a blanked cursor slot.
    set_a(4'd1, 4'd2, 4'd3, 4'd4);
    st_l = SL_A; enabled = 1'b1; index = 2'd2;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(1'b0);
      t = cyc / SCAN_DIV;
      if (t >= 1 && (t - 1) % 4 == 2 && (((t + 3) / 4) / BLINK_DIV) % 2 == 1 &&
          (cyc % SCAN_DIV) == 1)
        found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL blank_slot_search: no blanked slot within 400 cycles, want one");
    end
    #1 rst = 1'b0;
    sb_q.delete();
    #1 check_dark("reset_mid_slot");
    enabled = 1'b0;
    repeat (2) @(negedge clk);
    check_dark("reset_held");
    release_reset();
    repeat (60) step(1'b0);

    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL missing_outputs: %0d expected outputs never seen, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
